rv_decode_stage: RTL and testbench

Pipelined RV64I integer decode stage. Accepts 32-bit instruction words from fetch over a valid/ready handshake. Emits the ALU operation select code, register indices, a sign-extended immediate and operand-routing flags to the execute stage that hosts the base integer ALU. Contains a registered output with a one-entry skid buffer, so it sustains one instruction per cycle under arbitrary backpressure.

---
 rtl/rv_decode_stage.sv | 213 +++++++++++++++++++++
 tb/tb_rv_decode_stage.sv | 282 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rv_decode_stage.sv
// RV64I decode stage: combinational decode feeding an output register backed by
// a one-entry skid buffer, so fetch sees a registered ready and throughput is 1/cycle.
module rv_decode_stage #(
    parameter int XLEN = 64,
    parameter int OP_W = 5
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     in_instr,
    input  logic [XLEN-1:0] in_pc,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [OP_W-1:0] out_op,
    output logic [4:0]      out_rd,
    output logic [4:0]      out_rs1,
    output logic [4:0]      out_rs2,
    output logic [XLEN-1:0] out_imm,
    output logic            out_use_imm,
    output logic            out_use_pc,
    output logic            out_illegal,
    output logic [XLEN-1:0] out_pc
);

    typedef struct packed {
        logic [OP_W-1:0] op;
        logic [4:0]      rd;
        logic [4:0]      rs1;
        logic [4:0]      rs2;
        logic [XLEN-1:0] imm;
        logic            use_imm;
        logic            use_pc;
        logic            illegal;
        logic [XLEN-1:0] pc;
    } bundle_t;

    localparam logic [OP_W-1:0] OP_LUI = OP_W'(0),   OP_AUIPC = OP_W'(1),  OP_ADD = OP_W'(2),
                                OP_SUB = OP_W'(3),   OP_SLL = OP_W'(4),    OP_SLT = OP_W'(5),
                                OP_SLTU = OP_W'(6),  OP_XOR = OP_W'(7),    OP_SRL = OP_W'(8),
                                OP_SRA = OP_W'(9),   OP_OR = OP_W'(10),    OP_AND = OP_W'(11),
                                OP_FENCE = OP_W'(12), OP_FENCE_TSO = OP_W'(13), OP_PAUSE = OP_W'(14),
                                OP_ECALL = OP_W'(15), OP_EBREAK = OP_W'(16), OP_SLLI = OP_W'(17),
                                OP_SRLI = OP_W'(18), OP_SRAI = OP_W'(19),  OP_ADDIW = OP_W'(20),
                                OP_SLLIW = OP_W'(21), OP_SRLIW = OP_W'(22), OP_SRAIW = OP_W'(23),
                                OP_ADDW = OP_W'(24), OP_SUBW = OP_W'(25),  OP_SLLW = OP_W'(26),
                                OP_SRLW = OP_W'(27), OP_SRAW = OP_W'(28);

    bundle_t     dec_d;
    bundle_t     out_q, skid_q;
    logic        out_valid_q, skid_valid_q;
    logic        legal, alt;
    logic [6:0]  opc, f7;
    logic [2:0]  f3;
    logic        accept, out_load;

    assign opc = in_instr[6:0];
    assign f3  = in_instr[14:12];
    assign f7  = in_instr[31:25];
    assign alt = (f7 == 7'b0100000);

    always_comb begin
        dec_d    = '0;
        dec_d.pc = in_pc;
        legal    = 1'b1;
        unique case (opc)
            7'b0110011: begin
                dec_d.rd  = in_instr[11:7];
                dec_d.rs1 = in_instr[19:15];
                dec_d.rs2 = in_instr[24:20];
                // only ADD/SUB and SRL/SRA share a funct3 with an alternate funct7
                if (f7 != 7'b0 && !(alt && (f3 == 3'b000 || f3 == 3'b101))) legal = 1'b0;
                unique case (f3)
                    3'b000:  dec_d.op = alt ? OP_SUB : OP_ADD;
                    3'b001:  dec_d.op = OP_SLL;
                    3'b010:  dec_d.op = OP_SLT;
                    3'b011:  dec_d.op = OP_SLTU;
                    3'b100:  dec_d.op = OP_XOR;
                    3'b101:  dec_d.op = alt ? OP_SRA : OP_SRL;
                    3'b110:  dec_d.op = OP_OR;
                    default: dec_d.op = OP_AND;
                endcase
            end
            7'b0111011: begin
                dec_d.rd  = in_instr[11:7];
                dec_d.rs1 = in_instr[19:15];
                dec_d.rs2 = in_instr[24:20];
                if (f7 != 7'b0 && !(alt && (f3 == 3'b000 || f3 == 3'b101))) legal = 1'b0;
                unique case (f3)
                    3'b000:  dec_d.op = alt ? OP_SUBW : OP_ADDW;
                    3'b001:  dec_d.op = OP_SLLW;
                    3'b101:  dec_d.op = alt ? OP_SRAW : OP_SRLW;
                    default: legal = 1'b0;
                endcase
            end
            7'b0010011: begin
                dec_d.rd      = in_instr[11:7];
                dec_d.rs1     = in_instr[19:15];
                dec_d.use_imm = 1'b1;
                dec_d.imm     = {{(XLEN-12){in_instr[31]}}, in_instr[31:20]};
                unique case (f3)
                    3'b000:  dec_d.op = OP_ADD;
                    3'b010:  dec_d.op = OP_SLT;
                    3'b011:  dec_d.op = OP_SLTU;
                    3'b100:  dec_d.op = OP_XOR;
                    3'b110:  dec_d.op = OP_OR;
                    3'b111:  dec_d.op = OP_AND;
                    3'b001: begin
                        dec_d.op  = OP_SLLI;
                        dec_d.imm = {{(XLEN-6){1'b0}}, in_instr[25:20]};
                        if (in_instr[31:26] != 6'b0) legal = 1'b0;
                    end
                    default: begin
                        dec_d.op  = (in_instr[31:26] == 6'b010000) ? OP_SRAI : OP_SRLI;
                        dec_d.imm = {{(XLEN-6){1'b0}}, in_instr[25:20]};
                        if (in_instr[31:26] != 6'b0 && in_instr[31:26] != 6'b010000) legal = 1'b0;
                    end
                endcase
            end
            7'b0011011: begin
                dec_d.rd      = in_instr[11:7];
                dec_d.rs1     = in_instr[19:15];
                dec_d.use_imm = 1'b1;
                dec_d.imm     = {{(XLEN-5){1'b0}}, in_instr[24:20]};
                unique case (f3)
                    3'b000: begin
                        dec_d.op  = OP_ADDIW;
                        dec_d.imm = {{(XLEN-12){in_instr[31]}}, in_instr[31:20]};
                    end
                    3'b001: begin
                        dec_d.op = OP_SLLIW;
                        if (f7 != 7'b0) legal = 1'b0;
                    end
                    3'b101: begin
                        dec_d.op = alt ? OP_SRAIW : OP_SRLIW;
                        if (f7 != 7'b0 && !alt) legal = 1'b0;
                    end
                    default: legal = 1'b0;
                endcase
            end
            7'b0110111, 7'b0010111: begin
                dec_d.rd      = in_instr[11:7];
                dec_d.imm     = {{(XLEN-32){in_instr[31]}}, in_instr[31:12], 12'b0};
                dec_d.use_imm = 1'b1;
                dec_d.use_pc  = opc[5] ? 1'b0 : 1'b1;
                dec_d.op      = opc[5] ? OP_LUI : OP_AUIPC;
            end
            7'b0001111: begin
                dec_d.rd  = in_instr[11:7];
                dec_d.rs1 = in_instr[19:15];
                if (f3 != 3'b000)                   legal    = 1'b0;
                else if (in_instr == 32'h8330000F)  dec_d.op = OP_FENCE_TSO;
                else if (in_instr == 32'h0100000F)  dec_d.op = OP_PAUSE;
                else                                dec_d.op = OP_FENCE;
            end
            7'b1110011: begin
                if (in_instr == 32'h00000073)      dec_d.op = OP_ECALL;
                else if (in_instr == 32'h00100073) dec_d.op = OP_EBREAK;
                else                               legal    = 1'b0;
            end
            default: legal = 1'b0;
        endcase
        if (!legal) begin
            dec_d         = '0;
            dec_d.pc      = in_pc;
            dec_d.illegal = 1'b1;
        end
    end

    assign in_ready = !skid_valid_q;
    assign accept   = in_valid && in_ready;
    assign out_load = !out_valid_q || out_ready;

    // an accept never coincides with a full skid, so the skid branch never overwrites
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_q        <= '0;
            skid_q       <= '0;
            out_valid_q  <= 1'b0;
            skid_valid_q <= 1'b0;
        end else if (flush) begin
            out_valid_q  <= 1'b0;
            skid_valid_q <= 1'b0;
        end else if (out_load) begin
            if (skid_valid_q) begin
                out_q        <= skid_q;
                out_valid_q  <= 1'b1;
                skid_valid_q <= 1'b0;
            end else if (accept) begin
                out_q       <= dec_d;
                out_valid_q <= 1'b1;
            end else begin
                out_valid_q <= 1'b0;
            end
        end else if (accept) begin
            skid_q       <= dec_d;
            skid_valid_q <= 1'b1;
        end
    end

    assign out_valid   = out_valid_q;
    assign out_op      = out_q.op;
    assign out_rd      = out_q.rd;
    assign out_rs1     = out_q.rs1;
    assign out_rs2     = out_q.rs2;
    assign out_imm     = out_q.imm;
    assign out_use_imm = out_q.use_imm;
    assign out_use_pc  = out_q.use_pc;
    assign out_illegal = out_q.illegal;
    assign out_pc      = out_q.pc;

endmodule

// File: tb/tb_rv_decode_stage.sv
// Scoreboard bench for rv_decode_stage: driver queues expected bundles on accept,
// monitor pops and compares on every output transfer.
module tb_rv_decode_stage;
    localparam int XLEN = 64;
    localparam int OP_W = 5;
    localparam int NV   = 23;

    typedef struct packed {
        logic [4:0]  op;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [63:0] imm;
        logic        use_imm;
        logic        use_pc;
        logic        illegal;
        logic [63:0] pc;
    } exp_t;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic            flush = 1'b0;
    logic            in_valid = 1'b0;
    logic            in_ready;
    logic [31:0]     in_instr = '0;
    logic [XLEN-1:0] in_pc = '0;
    logic            out_valid;
    logic            out_ready = 1'b1;
    logic [OP_W-1:0] out_op;
    logic [4:0]      out_rd, out_rs1, out_rs2;
    logic [XLEN-1:0] out_imm, out_pc;
    logic            out_use_imm, out_use_pc, out_illegal;

    int   n_checks = 0;
    int   n_errors = 0;
    exp_t sb_q[$];
    logic [31:0] vec_instr [NV];
    exp_t        vec_exp   [NV];

    rv_decode_stage #(.XLEN(XLEN), .OP_W(OP_W)) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr), .in_pc(in_pc),
        .out_valid(out_valid), .out_ready(out_ready), .out_op(out_op),
        .out_rd(out_rd), .out_rs1(out_rs1), .out_rs2(out_rs2), .out_imm(out_imm),
        .out_use_imm(out_use_imm), .out_use_pc(out_use_pc), .out_illegal(out_illegal),
        .out_pc(out_pc)
    );

    always #5 clk = ~clk;

    function automatic exp_t mk(int op, int rd, int rs1, int rs2, logic [63:0] imm,
                                bit ui, bit up, bit ill);
        exp_t e;
        e.op = 5'(op); e.rd = 5'(rd); e.rs1 = 5'(rs1); e.rs2 = 5'(rs2);
        e.imm = imm; e.use_imm = ui; e.use_pc = up; e.illegal = ill; e.pc = '0;
        return e;
    endfunction

    function automatic exp_t expect_of(int idx, logic [63:0] pc);
        exp_t e;
        e    = vec_exp[idx];
        e.pc = pc;
        return e;
    endfunction

    task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // monitor: transfer compare plus hold-stability while stalled
    initial begin
        exp_t cur, prev, e;
        bit   prev_stall;
        prev_stall = 1'b0;
        prev = '0;
        forever begin
            @(negedge clk);
            cur.op = out_op; cur.rd = out_rd; cur.rs1 = out_rs1; cur.rs2 = out_rs2;
            cur.imm = out_imm; cur.use_imm = out_use_imm; cur.use_pc = out_use_pc;
            cur.illegal = out_illegal; cur.pc = out_pc;
            if (prev_stall) begin
                n_checks++;
                if (cur !== prev || out_valid !== 1'b1) begin
                    n_errors++;
                    $display("FAIL stall_hold: got %h valid=%b expected %h", cur, out_valid, prev);
                end
            end
            if (rst_n && !flush && out_valid && out_ready) begin
                n_checks++;
                if (sb_q.size() == 0) begin
                    n_errors++;
                    $display("FAIL unexpected_output: got %h expected none", cur);
                end else begin
                    e = sb_q.pop_front();
                    if (cur !== e) begin
                        n_errors++;
                        $display("FAIL bundle op=%0d pc=%h: got %h expected %h", e.op, e.pc, cur, e);
                    end
                end
            end
            prev       = cur;
            prev_stall = rst_n && !flush && out_valid && !out_ready;
        end
    end

    task automatic send(int idx, logic [63:0] pc);
        bit done;
        done     = 1'b0;
        in_valid = 1'b1;
        in_instr = vec_instr[idx];
        in_pc    = pc;
        for (int t = 0; t < 50 && !done; t++) begin
            @(negedge clk);
            if (in_ready && !flush) begin
                sb_q.push_back(expect_of(idx, pc));
                done = 1'b1;
            end
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        if (!done) chk("send_timeout", 0, 1);
    endtask

    task automatic drain(string name);
        bit ok;
        ok        = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        for (int t = 0; t < 50 && !ok; t++) begin
            @(posedge clk); #2;
            if (sb_q.size() == 0) ok = 1'b1;
        end
        chk(name, ok, 1);
        @(posedge clk); #1;
        @(negedge clk);
        chk({name, "_idle"}, out_valid, 0);
        @(posedge clk); #1;
    endtask

    task automatic chk_empty(string name);
        chk({name, "_valid"}, out_valid, 0);
        chk({name, "_ready"}, in_ready, 1);
    endtask

    initial begin
        vec_instr[0]  = 32'h002081B3; vec_exp[0]  = mk(2, 3, 1, 2, 64'h0, 0, 0, 0);
        vec_instr[1]  = 32'hFFF00093; vec_exp[1]  = mk(2, 1, 0, 0, 64'hFFFF_FFFF_FFFF_FFFF, 1, 0, 0);
        vec_instr[2]  = 32'h43F0D093; vec_exp[2]  = mk(19, 1, 1, 0, 64'd63, 1, 0, 0);
        vec_instr[3]  = 32'h123452B7; vec_exp[3]  = mk(0, 5, 0, 0, 64'h1234_5000, 1, 0, 0);
        vec_instr[4]  = 32'h12345297; vec_exp[4]  = mk(1, 5, 0, 0, 64'h1234_5000, 1, 1, 0);
        vec_instr[5]  = 32'h00000000; vec_exp[5]  = mk(0, 0, 0, 0, 64'h0, 0, 0, 1);
        vec_instr[6]  = 32'h402081B3; vec_exp[6]  = mk(3, 3, 1, 2, 64'h0, 0, 0, 0);
        vec_instr[7]  = 32'hFE0081B3; vec_exp[7]  = mk(0, 0, 0, 0, 64'h0, 0, 0, 1);
        vec_instr[8]  = 32'h800002B7; vec_exp[8]  = mk(0, 5, 0, 0, 64'hFFFF_FFFF_8000_0000, 1, 0, 0);
        vec_instr[9]  = 32'h0051009B; vec_exp[9]  = mk(20, 1, 2, 0, 64'd5, 1, 0, 0);
        vec_instr[10] = 32'h41F1509B; vec_exp[10] = mk(23, 1, 2, 0, 64'd31, 1, 0, 0);
        vec_instr[11] = 32'h402081BB; vec_exp[11] = mk(25, 3, 1, 2, 64'h0, 0, 0, 0);
        vec_instr[12] = 32'h02009093; vec_exp[12] = mk(17, 1, 1, 0, 64'd32, 1, 0, 0);
        vec_instr[13] = 32'h0200909B; vec_exp[13] = mk(0, 0, 0, 0, 64'h0, 0, 0, 1);
        vec_instr[14] = 32'h7FF1F113; vec_exp[14] = mk(11, 2, 3, 0, 64'h7FF, 1, 0, 0);
        vec_instr[15] = 32'h00000073; vec_exp[15] = mk(15, 0, 0, 0, 64'h0, 0, 0, 0);
        vec_instr[16] = 32'h00100073; vec_exp[16] = mk(16, 0, 0, 0, 64'h0, 0, 0, 0);
        vec_instr[17] = 32'h8330000F; vec_exp[17] = mk(13, 0, 0, 0, 64'h0, 0, 0, 0);
        vec_instr[18] = 32'h0100000F; vec_exp[18] = mk(14, 0, 0, 0, 64'h0, 0, 0, 0);
        vec_instr[19] = 32'h0FF0000F; vec_exp[19] = mk(12, 0, 0, 0, 64'h0, 0, 0, 0);
        vec_instr[20] = 32'h83F0D093; vec_exp[20] = mk(0, 0, 0, 0, 64'h0, 0, 0, 1);
        vec_instr[21] = 32'h007342B3; vec_exp[21] = mk(7, 5, 6, 7, 64'h0, 0, 0, 0);
        vec_instr[22] = 32'h4020D1BB; vec_exp[22] = mk(28, 3, 1, 2, 64'h0, 0, 0, 0);
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end

    initial begin
        // reset with fetch presenting a word: nothing may load
        in_valid = 1'b1; in_instr = 32'h002081B3; in_pc = 64'h1234;
        repeat (2) @(posedge clk);
        #1;
        @(negedge clk);
        chk_empty("reset");
        chk("reset_op", out_op, 0);
        chk("reset_rd", out_rd, 0);
        chk("reset_imm", out_imm, 0);
        chk("reset_pc", out_pc, 0);
        chk("reset_illegal", out_illegal, 0);
        @(posedge clk); #1;
        rst_n = 1'b1; in_valid = 1'b0;
        @(posedge clk); #1;

        // all vectors back-to-back, free-flowing output
        out_ready = 1'b1;
        for (int i = 0; i < NV; i++) send(i, 64'hFFFF_FFFF_8000_0000 + 64'(i * 4));
        drain("drain_stream");

        // 10-word stream with out_ready low on cycles 3..5
        begin
            int idx;
            idx = 0;
            for (int cyc = 0; cyc < 60 && idx < 10; cyc++) begin
                out_ready = !(cyc >= 3 && cyc <= 5);
                in_valid  = 1'b1;
                in_instr  = vec_instr[idx];
                in_pc     = 64'h1000 + 64'(idx * 4);
                @(negedge clk);
                if (cyc == 3) chk("in_ready_c3", in_ready, 1);
                if (cyc == 4) chk("in_ready_drop_c4", in_ready, 0);
                if (cyc == 6) chk("in_ready_c6", in_ready, 0);
                if (cyc == 7) chk("in_ready_back_c7", in_ready, 1);
                if (in_ready) begin
                    sb_q.push_back(expect_of(idx, 64'h1000 + 64'(idx * 4)));
                    idx++;
                end
                @(posedge clk); #1;
            end
            chk("stall_stream_sent", idx, 10);
        end
        drain("drain_stall");

        // flush with both entries full and fetch still presenting a word
        out_ready = 1'b0;
        send(0, 64'h2000);
        send(1, 64'h2004);
        @(negedge clk);
        chk("full_in_ready", in_ready, 0);
        @(posedge clk); #1;
        in_valid = 1'b1; in_instr = vec_instr[2]; in_pc = 64'h2008; flush = 1'b1;
        @(negedge clk);
        sb_q.delete();
        @(posedge clk); #1;
        flush = 1'b0; in_valid = 1'b0;
        @(negedge clk);
        chk_empty("flush_full");
        @(posedge clk); #1;
        out_ready = 1'b1;
        send(3, 64'h200C);
        drain("drain_flush_full");

        // flush while the presented word would otherwise be accepted
        out_ready = 1'b0;
        send(4, 64'h3000);
        in_valid = 1'b1; in_instr = vec_instr[6]; in_pc = 64'h3004; flush = 1'b1;
        @(negedge clk);
        chk("flush_in_ready_high", in_ready, 1);
        sb_q.delete();
        @(posedge clk); #1;
        flush = 1'b0; in_valid = 1'b0;
        @(negedge clk);
        chk_empty("flush_accepting");
        @(posedge clk); #1;
        send(21, 64'h3008);
        drain("drain_flush_acc");

        // reset mid-stream with both entries full
        out_ready = 1'b0;
        send(8, 64'h4000);
        send(9, 64'h4004);
        in_valid = 1'b1; in_instr = vec_instr[10]; in_pc = 64'h4008; rst_n = 1'b0;
        @(posedge clk); #1;
        sb_q.delete();
        in_valid = 1'b0;
        @(negedge clk);
        chk_empty("reset_mid");
        chk("reset_mid_op", out_op, 0);
        chk("reset_mid_imm", out_imm, 0);
        chk("reset_mid_pc", out_pc, 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        out_ready = 1'b1;
        send(22, 64'h400C);
        drain("drain_reset_mid");

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
